// File: rtl/engine_multiply_sequencer.sv
// Request front-end for the shift-add multiply engine: tagged request FIFO, single-issue FSM, tagged response.
// Optional feature macro SIGNED_MULT_EN adds req_signed and sign-magnitude handling around the engine.
module engine_multiply_sequencer #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 4,
    parameter int TAG_WIDTH = 4
) (
    input  logic                   clock,
    input  logic                   clock_areset_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [WIDTH-1:0]       req_a,
    input  logic [WIDTH-1:0]       req_b,
    input  logic [TAG_WIDTH-1:0]   req_tag,
`ifdef SIGNED_MULT_EN
    input  logic                   req_signed,
`endif
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [2*WIDTH-1:0]     rsp_result,
    output logic [TAG_WIDTH-1:0]   rsp_tag,
    output logic                   eng_clock_sreset,
    output logic [WIDTH-1:0]       eng_dataa,
    output logic [WIDTH-1:0]       eng_datab,
    output logic                   eng_go,
    input  logic                   eng_busy,
    input  logic                   eng_result_valid,
    input  logic [2*WIDTH-1:0]     eng_result
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t                 state_q, state_d;
    logic [1:0]             sreset_q;
    logic [PTR_W:0]         wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]         rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0]       op_a_q, op_a_d;
    logic [WIDTH-1:0]       op_b_q, op_b_d;
    logic [TAG_WIDTH-1:0]   tag_q, tag_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [2*WIDTH-1:0]     rsp_result_q, rsp_result_d;
    logic [TAG_WIDTH-1:0]   rsp_tag_q, rsp_tag_d;

    logic [WIDTH-1:0]       fifo_a_q   [DEPTH];
    logic [WIDTH-1:0]       fifo_b_q   [DEPTH];
    logic [TAG_WIDTH-1:0]   fifo_tag_q [DEPTH];

    logic                   full, empty, push, pop;
    logic [WIDTH-1:0]       head_a, head_b;
    logic [TAG_WIDTH-1:0]   head_tag;

    // The FSM never waits on busy; result_valid alone marks completion.
    logic                   unused_busy;
    assign unused_busy = eng_busy;

`ifdef SIGNED_MULT_EN
    logic                   fifo_sgn_q [DEPTH];
    logic                   head_sgn;
    logic                   sign_q, sign_d;

    // Two's complement magnitude; the most negative value maps to 2^(WIDTH-1) unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? (~x + WIDTH'(1)) : x;
    endfunction

    function automatic logic [2*WIDTH-1:0] negate(input logic [2*WIDTH-1:0] x);
        return ~x + (2*WIDTH)'(1);
    endfunction

    assign head_sgn = fifo_sgn_q[rd_ptr_q[PTR_W-1:0]];
`endif

    assign head_a   = fifo_a_q[rd_ptr_q[PTR_W-1:0]];
    assign head_b   = fifo_b_q[rd_ptr_q[PTR_W-1:0]];
    assign head_tag = fifo_tag_q[rd_ptr_q[PTR_W-1:0]];

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

    assign eng_clock_sreset = sreset_q[1];
    assign req_ready        = !full && !sreset_q[1];
    assign push             = req_valid && req_ready;

    assign eng_go     = (state_q == S_ISSUE);
    assign eng_dataa  = op_a_q;
    assign eng_datab  = op_b_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_tag    = rsp_tag_q;

    always_comb begin
        state_d      = state_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        tag_d        = tag_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_tag_d    = rsp_tag_q;
        pop          = 1'b0;
`ifdef SIGNED_MULT_EN
        sign_d       = sign_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!empty && !rsp_valid_q) begin
                    state_d = S_ISSUE;
`ifdef SIGNED_MULT_EN
                    op_a_d  = head_sgn ? magnitude(head_a) : head_a;
                    op_b_d  = head_sgn ? magnitude(head_b) : head_b;
`else
                    op_a_d  = head_a;
                    op_b_d  = head_b;
`endif
                end
            end
            S_ISSUE: begin
                pop     = 1'b1;
                tag_d   = head_tag;
`ifdef SIGNED_MULT_EN
                sign_d  = head_sgn && (head_a[WIDTH-1] ^ head_b[WIDTH-1]);
`endif
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (eng_result_valid) begin
`ifdef SIGNED_MULT_EN
                    rsp_result_d = sign_q ? negate(eng_result) : eng_result;
`else
                    rsp_result_d = eng_result;
`endif
                    rsp_tag_d    = tag_q;
                    rsp_valid_d  = 1'b1;
                    state_d      = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        wr_ptr_d = push ? wr_ptr_q + (PTR_W+1)'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + (PTR_W+1)'(1) : rd_ptr_q;
    end

    always_ff @(posedge clock or negedge clock_areset_n) begin
        if (!clock_areset_n) begin
            state_q      <= S_IDLE;
            sreset_q     <= 2'b11;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            tag_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_tag_q    <= '0;
`ifdef SIGNED_MULT_EN
            sign_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            sreset_q     <= {sreset_q[0], 1'b0};
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            tag_q        <= tag_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_tag_q    <= rsp_tag_d;
`ifdef SIGNED_MULT_EN
            sign_q       <= sign_d;
`endif
        end
    end

    // FIFO storage is data only; occupancy lives entirely in the pointers.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_a_q[wr_ptr_q[PTR_W-1:0]]   <= req_a;
            fifo_b_q[wr_ptr_q[PTR_W-1:0]]   <= req_b;
            fifo_tag_q[wr_ptr_q[PTR_W-1:0]] <= req_tag;
`ifdef SIGNED_MULT_EN
            fifo_sgn_q[wr_ptr_q[PTR_W-1:0]] <= req_signed;
`endif
        end
    end

endmodule

// File: tb/tb_engine_multiply_sequencer.sv
// Directed bench for engine_multiply_sequencer with a behavioural multiply engine alongside.
// Signed vectors are exercised when SIGNED_MULT_EN is defined.
module tb_engine_multiply_sequencer;

    localparam int WIDTH     = 32;
    localparam int DEPTH     = 4;
    localparam int TAG_WIDTH = 4;

    logic                 clock = 1'b0;
    logic                 clock_areset_n;
    logic                 req_valid;
    logic                 req_ready;
    logic [WIDTH-1:0]     req_a;
    logic [WIDTH-1:0]     req_b;
    logic [TAG_WIDTH-1:0] req_tag;
`ifdef SIGNED_MULT_EN
    logic                 req_signed;
`endif
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [2*WIDTH-1:0]   rsp_result;
    logic [TAG_WIDTH-1:0] rsp_tag;
    logic                 eng_clock_sreset;
    logic [WIDTH-1:0]     eng_dataa;
    logic [WIDTH-1:0]     eng_datab;
    logic                 eng_go;
    logic                 eng_busy;
    logic                 eng_result_valid;
    logic [2*WIDTH-1:0]   eng_result;

    always #5 clock = ~clock;

    engine_multiply_sequencer #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_WIDTH(TAG_WIDTH)
    ) dut (
        .clock(clock),
        .clock_areset_n(clock_areset_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a(req_a),
        .req_b(req_b),
        .req_tag(req_tag),
`ifdef SIGNED_MULT_EN
        .req_signed(req_signed),
`endif
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_result(rsp_result),
        .rsp_tag(rsp_tag),
        .eng_clock_sreset(eng_clock_sreset),
        .eng_dataa(eng_dataa),
        .eng_datab(eng_datab),
        .eng_go(eng_go),
        .eng_busy(eng_busy),
        .eng_result_valid(eng_result_valid),
        .eng_result(eng_result)
    );

    // Behavioural engine: 5-cycle latency, 2 cycles when an operand is zero.
    logic [WIDTH-1:0]   m_a, m_b;
    logic [3:0]         m_cnt;
    logic               m_busy, m_rv, force_rv;
    logic [2*WIDTH-1:0] m_res;

    always @(posedge clock) begin
        m_rv <= 1'b0;
        if (eng_clock_sreset) begin
            m_busy <= 1'b0;
            m_cnt  <= 4'd0;
        end else if (eng_go && !m_busy) begin
            m_a    <= eng_dataa;
            m_b    <= eng_datab;
            m_busy <= 1'b1;
            m_cnt  <= (eng_dataa == 0 || eng_datab == 0) ? 4'd2 : 4'd5;
        end else if (m_busy) begin
            if (m_cnt == 4'd1) begin
                m_busy <= 1'b0;
                m_rv   <= 1'b1;
                m_res  <= {32'b0, m_a} * {32'b0, m_b};
            end
            m_cnt <= m_cnt - 4'd1;
        end
    end

    assign eng_busy         = m_busy;
    assign eng_result_valid = m_rv | force_rv;
    assign eng_result       = force_rv ? 64'h0000_0000_0000_0123 :
                              (m_rv ? m_res : 64'hDEAD_BEEF_DEAD_BEEF);

    int checks = 0;
    int errors = 0;
    int go_cnt = 0, go_run = 0, go_run_max = 0, rsp_t9 = 0;

    always @(negedge clock) begin
        if (eng_go) begin
            go_cnt++;
            go_run++;
            if (go_run > go_run_max) go_run_max = go_run;
        end else begin
            go_run = 0;
        end
        if (rsp_valid && rsp_tag == 4'd9) rsp_t9++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
        int n = 0;
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        req_tag   = t;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("push_timeout", 64'd0, 64'd1);
        tick();
        req_valid = 1'b0;
    endtask

`ifdef SIGNED_MULT_EN
    task automatic push_s(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t, input logic s);
        req_signed = s;
        push(a, b, t);
        req_signed = 1'b0;
    endtask
`endif

    task automatic expect_rsp(input string name, input logic [63:0] res, input logic [3:0] t);
        int n = 0;
        rsp_ready = 1'b1;
        while (!rsp_valid && n < 100) begin
            tick();
            n++;
        end
        check({name, "_valid"}, 64'(rsp_valid), 64'd1);
        check({name, "_result"}, rsp_result, res);
        check({name, "_tag"}, 64'(rsp_tag), 64'(t));
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0;
        int n;
        clock_areset_n = 1'b0;
        req_valid = 1'b0;
        req_a = '0;
        req_b = '0;
        req_tag = '0;
        rsp_ready = 1'b0;
        force_rv = 1'b0;
`ifdef SIGNED_MULT_EN
        req_signed = 1'b0;
`endif
        tick();
        tick();
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_result", rsp_result, 64'd0);
        check("rst_sreset", 64'(eng_clock_sreset), 64'd1);
        check("rst_go", 64'(eng_go), 64'd0);
        check("rst_dataa", 64'(eng_dataa), 64'd0);

        clock_areset_n = 1'b1;
        tick();
        check("sreset_hold1", 64'(eng_clock_sreset), 64'd1);
        check("ready_hold1", 64'(req_ready), 64'd0);
        tick();
        check("sreset_release", 64'(eng_clock_sreset), 64'd0);
        check("ready_release", 64'(req_ready), 64'd1);

        // Single request and issue latency
        g0 = go_cnt;
        push(32'd6, 32'd7, 4'd3);
        check("t1_go_early", 64'(eng_go), 64'd0);
        tick();
        check("t1_go_cycle2", 64'(eng_go), 64'd1);
        check("t1_dataa", 64'(eng_dataa), 64'd6);
        check("t1_datab", 64'(eng_datab), 64'd7);
        expect_rsp("t1", 64'd42, 4'd3);
        check("t1_go_count", 64'(go_cnt - g0), 64'd1);
        check("t1_go_width", 64'(go_run_max), 64'd1);

        // Back-to-back requests returned in order
        push(32'd3, 32'd5, 4'd1);
        push(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd2);
        push(32'd0, 32'd9, 4'd3);
        expect_rsp("t2a", 64'd15, 4'd1);
        expect_rsp("t2b", 64'hFFFF_FFFE_0000_0001, 4'd2);
        expect_rsp("t2c", 64'd0, 4'd3);

        // Fill with consumer stalled
        g0 = go_cnt;
        push(32'd1, 32'd1, 4'd4);
        push(32'd2, 32'd3, 4'd5);
        push(32'd4, 32'd4, 4'd6);
        push(32'd5, 32'd5, 4'd7);
        push(32'd10, 32'd10, 4'd8);
        check("t3_full_ready", 64'(req_ready), 64'd0);
        for (int i = 0; i < 20; i++) tick();
        check("t3_hold_valid", 64'(rsp_valid), 64'd1);
        check("t3_hold_result", rsp_result, 64'd1);
        for (int i = 0; i < 5; i++) tick();
        check("t3_stable_result", rsp_result, 64'd1);
        check("t3_stable_tag", 64'(rsp_tag), 64'd4);
        check("t3_single_go", 64'(go_cnt - g0), 64'd1);
        expect_rsp("t3a", 64'd1, 4'd4);
        expect_rsp("t3b", 64'd6, 4'd5);
        expect_rsp("t3c", 64'd16, 4'd6);
        expect_rsp("t3d", 64'd25, 4'd7);
        expect_rsp("t3e", 64'd100, 4'd8);
        check("t3_drained_ready", 64'(req_ready), 64'd1);

        // Reset while the engine is working
        push(32'd7, 32'd7, 4'd9);
        n = 0;
        while (!eng_go && n < 20) begin
            tick();
            n++;
        end
        check("t4_go_seen", 64'(eng_go), 64'd1);
        tick();
        tick();
        clock_areset_n = 1'b0;
        #1;
        check("t4_rst_valid", 64'(rsp_valid), 64'd0);
        check("t4_rst_sreset", 64'(eng_clock_sreset), 64'd1);
        check("t4_rst_ready", 64'(req_ready), 64'd0);
        check("t4_rst_dataa", 64'(eng_dataa), 64'd0);
        tick();
        tick();
        clock_areset_n = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        check("t4_no_rsp", 64'(rsp_valid), 64'd0);
        push(32'd2, 32'd2, 4'd1);
        expect_rsp("t4_after", 64'd4, 4'd1);
        check("t4_tag9_never", 64'(rsp_t9), 64'd0);

        // Spurious completion while idle
        g0 = go_cnt;
        force_rv = 1'b1;
        tick();
        force_rv = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("t5_no_rsp", 64'(rsp_valid), 64'd0);
        check("t5_ready", 64'(req_ready), 64'd1);
        check("t5_no_go", 64'(go_cnt - g0), 64'd0);
        push(32'd3, 32'd3, 4'd2);
        expect_rsp("t5_after", 64'd9, 4'd2);

`ifdef SIGNED_MULT_EN
        push_s(32'hFFFF_FFFD, 32'd7, 4'd1, 1'b1);
        expect_rsp("t6a", 64'hFFFF_FFFF_FFFF_FFEB, 4'd1);
        push_s(32'h8000_0000, 32'd2, 4'd2, 1'b1);
        expect_rsp("t6b", 64'hFFFF_FFFF_0000_0000, 4'd2);
        push_s(32'hFFFF_FFFD, 32'd7, 4'd3, 1'b0);
        expect_rsp("t6c", 64'h0000_0006_FFFF_FFEB, 4'd3);
        push_s(32'h8000_0000, 32'd2, 4'd4, 1'b0);
        expect_rsp("t6d", 64'h0000_0001_0000_0000, 4'd4);
`endif

        check("go_width_all", 64'(go_run_max), 64'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
